bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1, where 1 means MSB first and 0 means LSB first.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port din, input, WIDTH bits: the parallel word to serialize.
REQ-006 Port din_valid, input, 1 bit: din holds a word offered for transfer.
REQ-007 Port din_ready, output, 1 bit: the block can accept din this cycle.
REQ-008 Port en, input, 1 bit: downstream advance enable; 0 stalls bit delivery.
REQ-009 Port x, output, 1 bit: serial bit stream feeding the downstream sequence detector.
REQ-010 Port x_valid, output, 1 bit: x carries a new bit this cycle.
REQ-011 Port last, output, 1 bit: the current valid bit is the final bit of its word.
REQ-012 Port busy, output, 1 bit: a word is in progress (state SHIFT).

Function
REQ-013 The state machine SHALL have two states, IDLE and SHIFT, plus a registered shift register of WIDTH bits and a bit counter of $clog2(WIDTH) bits.
REQ-014 A transfer SHALL occur when din_valid && din_ready at a rising edge, and din is captured into the shift register on that edge.
REQ-015 din_ready SHALL be 1 in IDLE, and 1 in SHIFT only when last && en (back-to-back accept); it SHALL be 0 otherwise and whenever rst=1.
REQ-016 IDLE -> SHIFT on a transfer; counter is cleared to 0.
REQ-017 SHIFT -> SHIFT when a bit is delivered (x_valid=1) with count < WIDTH-1; the counter increments and the shift register shifts toward the output end.
REQ-018 On the final bit (count = WIDTH-1, x_valid=1): if a transfer also occurs, the block SHALL stay in SHIFT, load the new word and clear the counter (no bubble); otherwise it SHALL go SHIFT -> IDLE.
REQ-019 x SHALL be shift-register bit WIDTH-1 when MSB_FIRST=1, or bit 0 when MSB_FIRST=0; x SHALL be 0 in IDLE.
REQ-020 x_valid SHALL equal (state==SHIFT) && en; each bit SHALL be presented under x_valid exactly once.
REQ-021 When en=0 in SHIFT, the shift register, counter and x SHALL hold, and no transfer SHALL occur.
REQ-022 last SHALL equal x_valid && (count == WIDTH-1).
REQ-023 busy SHALL equal (state==SHIFT).
REQ-024 Latency: the first bit of an accepted word SHALL appear on x with x_valid=1 in the cycle immediately after the transfer edge, provided en=1.
REQ-025 din and din_valid SHALL be ignored when din_ready=0; the offered word is held by the source until accepted.
REQ-026 A word SHALL occupy exactly WIDTH x_valid cycles; throughput SHALL be one bit per cycle while en=1 and words are supplied continuously.

Reset
REQ-027 When rst=1 at a rising edge, the state SHALL become IDLE, and the counter and shift register SHALL become 0.
REQ-028 After reset, outputs SHALL be x=0, x_valid=0, last=0 and busy=0, and din_ready SHALL be 1 on the first cycle after rst falls.
REQ-029 Reset asserted mid-word SHALL discard the remaining bits; no partial word SHALL resume.
REQ-030 Reset SHALL take priority over a simultaneous transfer.

Verification
REQ-031 Reset check: rst=1 for 2 cycles with din_valid=1 and din=8'hFF -> din_ready=0, x_valid=0 and x=0 throughout; after release din_ready=1 and busy=0.
REQ-032 Single word, MSB_FIRST=1, en=1: din=8'hE8 accepted -> x=1,1,1,0,1,0,0,0 on 8 consecutive x_valid cycles starting the next cycle; last=1 only on the 8th; then busy=0.
REQ-033 Back-to-back: 8'hE8 then 8'h1D with din_valid held -> 16 consecutive x_valid cycles, x=11101000 00011101; second accept occurs on the cycle where last=1.
REQ-034 Stall: en=0 for 3 cycles after the 3rd bit of 8'hE8 -> x_valid=0 and x held at 0 for those 3 cycles; the remaining bits 0,1,0,0,0 follow with no bit lost or repeated.
REQ-035 LSB first: MSB_FIRST=0 and din=8'hE8 -> x=0,0,0,1,0,1,1,1.
REQ-036 Mid-word reset: rst=1 for 1 cycle after 3 bits of 8'hE8 -> x_valid=0 and busy=0 on the next cycle, and the next accepted word 8'h1D serializes cleanly as 00011101.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready load port and a stallable
// serial output. Back-to-back words are accepted on the final bit with no bubble.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             en,
   output logic             x,
   output logic             x_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             xfer;

   always_comb begin
      state_nx  = state;
      busy      = (state == SHIFT);
      x_valid   = (state == SHIFT) && en;
      last      = x_valid && (cnt == LAST_CNT);
      // ready during SHIFT only on a delivered final bit, so a stall never loads
      din_ready = !rst && ((state == IDLE) || last);
      xfer      = din_valid && din_ready;
      x         = 1'b0;
      case (state)
         IDLE: begin
            if (xfer) state_nx = SHIFT;
         end
         SHIFT: begin
            x = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            if (last && !xfer) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (xfer) begin
            sreg <= din;
            cnt  <= '0;
         end else if (x_valid) begin
            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            cnt  <= last ? '0 : cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share inputs;
// directed vector table plus random traffic against a word/bit-index reference model.
module tb_bit_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       en;
   logic [1:0] rdy, xo, xv, lst, bsy;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
      .en(en), .x(xo[0]), .x_valid(xv[0]), .last(lst[0]), .busy(bsy[0]));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
      .en(en), .x(xo[1]), .x_valid(xv[1]), .last(lst[1]), .busy(bsy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       rst, dv;
      logic [7:0] din;
      logic       en, r, xv, x, l, b;
   } vec_t;
   vec_t tbl[$];

   // reference model: current word, index of the next bit to deliver, busy flag
   logic [7:0] m_word[2];
   int         m_idx[2];
   bit         m_busy[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_exp(input int i, output logic er, output logic exv,
                                     output logic ex, output logic el, output logic eb);
      eb  = m_busy[i];
      exv = m_busy[i] && en;
      el  = exv && (m_idx[i] == 7);
      ex  = m_busy[i] ? m_word[i][(i == 0) ? 7 - m_idx[i] : m_idx[i]] : 1'b0;
      er  = !rst && (!m_busy[i] || el);
   endfunction

   task automatic model_check();
      logic er, exv, ex, el, eb;
      for (int i = 0; i < 2; i++) begin
         model_exp(i, er, exv, ex, el, eb);
         chk($sformatf("model%0d.din_ready", i), rdy[i], er);
         chk($sformatf("model%0d.x_valid", i), xv[i], exv);
         chk($sformatf("model%0d.x", i), xo[i], ex);
         chk($sformatf("model%0d.last", i), lst[i], el);
         chk($sformatf("model%0d.busy", i), bsy[i], eb);
      end
   endtask

   task automatic model_update();
      logic er, exv, ex, el, eb;
      for (int i = 0; i < 2; i++) begin
         model_exp(i, er, exv, ex, el, eb);
         if (rst) begin
            m_busy[i] = 1'b0;
            m_idx[i]  = 0;
         end else begin
            if (exv) m_idx[i]++;
            if (din_valid && er) begin
               m_word[i] = din;
               m_idx[i]  = 0;
               m_busy[i] = 1'b1;
            end else if (m_idx[i] == 8) begin
               m_busy[i] = 1'b0;
               m_idx[i]  = 0;
            end
         end
      end
   endtask

   task automatic drive(input logic r, input logic dv, input logic [7:0] d, input logic e);
      rst = r; din_valid = dv; din = d; en = e;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic cyc(input logic r, input logic dv, input logic [7:0] d, input logic e);
      drive(r, dv, d, e);
      model_check();
      tick();
   endtask

   task automatic add(input logic r, input logic dv, input logic [7:0] d, input logic e,
                      input logic er, input logic exv, input logic ex, input logic el,
                      input logic eb);
      vec_t v;
      v.rst = r; v.dv = dv; v.din = d; v.en = e;
      v.r = er; v.xv = exv; v.x = ex; v.l = el; v.b = eb;
      tbl.push_back(v);
   endtask

   // eight delivery cycles of an MSB-first stream; ready only on the final bit
   task automatic add_word(input logic [7:0] pat, input logic dv, input logic [7:0] d);
      for (int i = 0; i < 8; i++)
         add(1'b0, dv, d, 1'b1, i == 7, 1'b1, pat[7-i], i == 7, 1'b1);
   endtask

   initial begin
      logic [7:0] got;
      int         nb;
      logic       r, dv, e;

      // reset with a word offered, then single word
      add(1, 1, 8'hFF, 1, 0, 0, 0, 0, 0);
      add(1, 1, 8'hFF, 1, 0, 0, 0, 0, 0);
      add(0, 1, 8'hE8, 1, 1, 0, 0, 0, 0);
      add_word(8'hE8, 1'b0, 8'h00);
      add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
      // back-to-back, second word held until accepted on the last bit
      add(0, 1, 8'hE8, 1, 1, 0, 0, 0, 0);
      add_word(8'hE8, 1'b1, 8'h1D);
      add_word(8'h1D, 1'b0, 8'h00);
      add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
      // stall after the third bit
      add(0, 1, 8'hE8, 1, 1, 0, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 1);
      for (int k = 0; k < 3; k++) add(0, 1, 8'h1D, 0, 0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 1, 1, 0, 1, 1);
      add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
      // reset mid-word, then a clean word
      add(0, 1, 8'hE8, 1, 1, 0, 0, 0, 0);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 1);
      add(1, 1, 8'hAA, 1, 0, 1, 0, 0, 1);
      add(0, 1, 8'h1D, 1, 1, 0, 0, 0, 0);
      add_word(8'h1D, 1'b0, 8'h00);
      add(0, 0, 8'h00, 1, 1, 0, 0, 0, 0);

      @(negedge clk);
      drive(1, 0, 8'h00, 1);
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].dv, tbl[i].din, tbl[i].en);
         chk($sformatf("tbl%0d.din_ready", i), rdy[0], tbl[i].r);
         chk($sformatf("tbl%0d.x_valid", i), xv[0], tbl[i].xv);
         chk($sformatf("tbl%0d.x", i), xo[0], tbl[i].x);
         chk($sformatf("tbl%0d.last", i), lst[0], tbl[i].l);
         chk($sformatf("tbl%0d.busy", i), bsy[0], tbl[i].b);
         model_check();
         tick();
      end

      // LSB-first stream of 8'hE8, collected first bit leftmost
      cyc(1, 0, 8'h00, 1);
      cyc(0, 1, 8'hE8, 1);
      got = '0;
      nb  = 0;
      for (int k = 0; k < 20 && nb < 8; k++) begin
         drive(0, 0, 8'h00, 1);
         if (xv[1]) begin
            got = {got[6:0], xo[1]};
            nb++;
         end
         model_check();
         tick();
      end
      chk("lsb.bit_count", nb, 8);
      chk("lsb.stream", got, 8'h17);

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         r  = ($urandom_range(0, 99) == 0);
         dv = ($urandom_range(0, 2) != 0);
         e  = ($urandom_range(0, 3) != 0);
         cyc(r, dv, 8'($urandom), e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
